bomb_ctrl: RTL



---
 rtl/hero_pkg.sv | 33 +++
 rtl/key_sync_edge.sv | 28 ++
 rtl/bomb_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/hero_pkg.sv
// Shared game constants, bomb count encodings, bomb FSM states.
// Also a clamp helper used for placing sprites on screen.
package hero_pkg;

  localparam int X_PIXELS  = 635;
  localparam int Y_PIXELS  = 475;
  localparam int BOMB_SIZE = 10;

  localparam logic [3:0] B_NONE  = 4'd0;
  localparam logic [3:0] B_FUSE1 = 4'd1;
  localparam logic [3:0] B_FUSE2 = 4'd2;
  localparam logic [3:0] B_BLAST = 4'd3;

  typedef enum logic [1:0] {
    IDLE,
    FUSE,
    BLAST
  } bomb_state_t;

  function automatic logic [9:0] clamp10(
    input logic [10:0] v,
    input int          lo,
    input int          hi
  );
    if (v < 11'(lo))
      return 10'(lo);
    else if (v > 11'(hi))
      return 10'(hi);
    else
      return v[9:0];
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Key synchronizer: 2 flops into clk domain, then rising-edge pulse.
// Ports: clk, rst_n, key (async raw), press (1-cycle pulse per rise).
module key_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= key;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign press = s2 & ~s3;

endmodule

// File: rtl/bomb_ctrl.sv
// Bomb drop, fuse countdown, blast hold and per-level bomb stock.
// Ports: clk, rst_n, enable, level_start, f_key, char_pos_x/y in;
//        bomb_pos_x/y, b_cnt, blast, bombs_left out (all registered).
module bomb_ctrl
  import hero_pkg::*;
#(
  parameter int TICK_CYCLES     = 12500000,
  parameter int BLAST_CYCLES    = 6250000,
  parameter int BOMBS_PER_LEVEL = 6,
  parameter int FOOT_OFFSET     = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       level_start,
  input  logic       f_key,
  input  logic [9:0] char_pos_x,
  input  logic [9:0] char_pos_y,
  output logic [9:0] bomb_pos_x,
  output logic [9:0] bomb_pos_y,
  output logic [3:0] b_cnt,
  output logic       blast,
  output logic [2:0] bombs_left
);

  localparam int CMAX = (TICK_CYCLES > BLAST_CYCLES)
                      ? TICK_CYCLES : BLAST_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] TICK_END  = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] BLAST_END = CW'(BLAST_CYCLES - 1);
  localparam logic [2:0]    STOCK     = 3'(BOMBS_PER_LEVEL);

  bomb_state_t   state;
  logic [CW-1:0] cnt;
  logic          press;
  logic [10:0]   foot_y;

  key_sync_edge u_fkey (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (f_key),
    .press (press)
  );

  // 11-bit sum so a hero near the bottom cannot wrap to the top
  assign foot_y = {1'b0, char_pos_y} + 11'(FOOT_OFFSET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bomb_pos_x <= '0;
      bomb_pos_y <= '0;
      b_cnt      <= B_NONE;
      blast      <= 1'b0;
      bombs_left <= STOCK;
    end else begin
      blast <= 1'b0;
      if (level_start) begin
        bombs_left <= STOCK;
        state      <= IDLE;
        b_cnt      <= B_NONE;
        cnt        <= '0;
      end else if (!enable) begin
        state <= IDLE;
        b_cnt <= B_NONE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            b_cnt <= B_NONE;
            if (press && bombs_left != 3'd0) begin
              bomb_pos_x <= clamp10({1'b0, char_pos_x},
                                    BOMB_SIZE,
                                    X_PIXELS - BOMB_SIZE);
              bomb_pos_y <= clamp10(foot_y,
                                    BOMB_SIZE,
                                    Y_PIXELS - BOMB_SIZE);
              bombs_left <= bombs_left - 3'd1;
              b_cnt      <= B_FUSE1;
              cnt        <= '0;
              state      <= FUSE;
            end
          end
          FUSE: begin
            if (cnt == TICK_END) begin
              cnt <= '0;
              if (b_cnt == B_FUSE1) begin
                b_cnt <= B_FUSE2;
              end else begin
                b_cnt <= B_BLAST;
                blast <= 1'b1;
                state <= BLAST;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          BLAST: begin
            if (cnt == BLAST_END) begin
              cnt   <= '0;
              b_cnt <= B_NONE;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            b_cnt <= B_NONE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
